// File: rtl/apb_pkg.sv
// apb_pkg: shared APB completer types and constants (state enum, address and wait-counter widths)
package apb_pkg;

    localparam int APB_AW     = 32;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } apb_slv_state_t;

endpackage

// File: rtl/apb_wait_counter.sv
// apb_wait_counter: loadable down-counter that flags the cycle before it reaches zero
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    output logic [WAIT_CNT_W-1:0] count,
    output logic                  done_next
);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    // load takes priority; otherwise count down and hold at zero
    always_comb begin
        cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count     = cnt_q;
    assign done_next = (cnt_q == WAIT_CNT_W'(1));

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer with zero-initialised word memory, registered outputs, PSLVERR on
// address miss or misalignment, and wait states enabled by the APB_SLV_WAIT_EN macro
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 16,
    parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h1111_0000,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [APB_AW-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int IDX_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15 ||
        BASE_ADDR[IDX_W+1:0] != '0) begin : g_bad_param
        $error("apb_slave_mem: illegal parameterisation");
    end

    apb_slv_state_t    state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              write_q, write_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [IDX_W-1:0]  paddr_idx;
    logic              paddr_hit;

    assign paddr_idx = PADDR[IDX_W+1:2];
    assign paddr_hit = (PADDR[APB_AW-1:IDX_W+2] == BASE_ADDR[APB_AW-1:IDX_W+2]) && (PADDR[1:0] == 2'b00);

`ifdef APB_SLV_WAIT_EN
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT = WAIT_CNT_W'(WAIT_CYCLES);

    logic                  cnt_load;
    logic                  cnt_done_next;
    logic [WAIT_CNT_W-1:0] cnt;

    apb_wait_counter u_wait (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .load     (cnt_load),
        .load_val (WAIT_CNT),
        .count    (cnt),
        .done_next(cnt_done_next)
    );
`endif

    // next-state, registered-output and memory-update logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        write_d   = write_q;
        hit_d     = hit_q;
        wdata_d   = wdata_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        mem_d     = mem_q;
`ifdef APB_SLV_WAIT_EN
        cnt_load  = 1'b0;
`endif
        case (state_q)
            IDLE: if (PSEL && !PENABLE) begin
                idx_d     = paddr_idx;
                write_d   = PWRITE;
                hit_d     = paddr_hit;
                wdata_d   = PWDATA;
                state_d   = RESP;
                pready_d  = 1'b1;
                pslverr_d = !paddr_hit;
                prdata_d  = (paddr_hit && !PWRITE) ? mem_q[paddr_idx] : '0;
`ifdef APB_SLV_WAIT_EN
                if (WAIT_CNT != '0) begin
                    state_d   = WAIT;
                    cnt_load  = 1'b1;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end
`endif
            end
`ifdef APB_SLV_WAIT_EN
            WAIT: if (!PSEL) begin
                state_d = IDLE;
            end else if (cnt_done_next || cnt == '0) begin
                state_d   = RESP;
                pready_d  = 1'b1;
                pslverr_d = !hit_q;
                prdata_d  = (hit_q && !write_q) ? mem_q[idx_q] : '0;
            end
`endif
            RESP: begin
                state_d = IDLE;
                if (PSEL && PENABLE && hit_q && write_q) mem_d[idx_q] = wdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, latched transfer, outputs and memory with asynchronous clear
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            write_q   <= 1'b0;
            hit_q     <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            hit_q     <= hit_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            mem_q     <= mem_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: scoreboard bench for apb_slave_mem in either APB_SLV_WAIT_EN build
module tb_apb_slave_mem;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 16;
    localparam int          WAITC  = 3;
    localparam logic [31:0] BASE   = 32'h1111_0000;
`ifdef APB_SLV_WAIT_EN
    localparam int          EXP_WAIT = WAITC;
`else
    localparam int          EXP_WAIT = 0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    exp_t        sb_q[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          fails  = 0;

    apb_slave_mem #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic hit_of(input logic [31:0] a);
        return (a[31:6] == BASE[31:6]) && (a[1:0] == 2'b00);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic idle();
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   n;
        e.err   = !hit_of(a);
        e.rdata = (!wr && !e.err) ? model[a[5:2]] : '0;
        sb_q.push_back(e);
        @(negedge PCLK);
        checks++;
        if (PREADY !== 1'b0) begin
            fails++;
            $display("FAIL pready_gap addr=%h got %b want 0", a, PREADY);
        end
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        n = 0;
        while (PREADY !== 1'b1 && n <= EXP_WAIT + 4) begin
            @(negedge PCLK);
            n++;
        end
        e = sb_q.pop_front();
        checks++;
        if (n != EXP_WAIT) begin
            fails++;
            $display("FAIL wait_count addr=%h got %0d want %0d", a, n, EXP_WAIT);
        end
        if (PREADY === 1'b1) begin
            checks++;
            if (PRDATA !== e.rdata) begin
                fails++;
                $display("FAIL prdata addr=%h got %h want %h", a, PRDATA, e.rdata);
            end
            checks++;
            if (PSLVERR !== e.err) begin
                fails++;
                $display("FAIL pslverr addr=%h got %b want %b", a, PSLVERR, e.err);
            end
        end
        if (wr && !e.err) model[a[5:2]] = wd;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        model_clear();
        #1;
        checks += 3;
        if (PREADY !== 1'b0)  begin fails++; $display("FAIL reset_pready got %b want 0", PREADY); end
        if (PSLVERR !== 1'b0) begin fails++; $display("FAIL reset_pslverr got %b want 0", PSLVERR); end
        if (PRDATA !== '0)    begin fails++; $display("FAIL reset_prdata got %h want 0", PRDATA); end
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        xfer(1'b1, BASE + 32'h4, 32'h0000_0055);
        xfer(1'b1, BASE + 32'h14, 32'h0000_0066);
        @(negedge PCLK);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = BASE + 32'h4;
        @(negedge PCLK);
        PENABLE = 1'b1;
        PRESETn = 1'b0;
        #1;
        checks += 3;
        if (PREADY !== 1'b0)  begin fails++; $display("FAIL midreset_pready got %b want 0", PREADY); end
        if (PSLVERR !== 1'b0) begin fails++; $display("FAIL midreset_pslverr got %b want 0", PSLVERR); end
        if (PRDATA !== '0)    begin fails++; $display("FAIL midreset_prdata got %h want 0", PRDATA); end
        model_clear();
        idle();
        @(negedge PCLK);
        PRESETn = 1'b1;
        xfer(1'b0, BASE + 32'h4, '0);
        xfer(1'b0, BASE + 32'h14, '0);
        idle();
    endtask

    task automatic test_zero_wait();
        xfer(1'b1, BASE + 32'h8, 32'hDEAD_BEEF);
        xfer(1'b0, BASE + 32'h8, '0);
        idle();
    endtask

    task automatic test_wait_states();
        xfer(1'b0, BASE + 32'h3C, '0);
        xfer(1'b1, BASE + 32'h3C, 32'h1234_5678);
        xfer(1'b0, BASE + 32'h3C, '0);
        idle();
    endtask

    task automatic test_error();
        xfer(1'b1, 32'h1211_1111, 32'h5);
        xfer(1'b1, BASE + 32'h2, 32'h9);
        xfer(1'b0, 32'h2222_0000, '0);
        xfer(1'b0, BASE + 32'h41, '0);
        for (int i = 0; i < DEPTH; i++) xfer(1'b0, BASE + 32'(i * 4), '0);
        idle();
    endtask

    task automatic test_back_to_back();
        xfer(1'b1, BASE, 32'h0000_0A0B);
        xfer(1'b0, BASE, '0);
        xfer(1'b1, BASE + 32'h24, 32'hCAFE_F00D);
        xfer(1'b1, BASE, 32'h0000_0C0D);
        xfer(1'b0, BASE + 32'h24, '0);
        xfer(1'b0, BASE, '0);
        idle();
    endtask

    task automatic test_abort();
        @(negedge PCLK);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = BASE + 32'h10;
        PWDATA  = 32'h7;
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge PCLK);
            checks++;
            if (PREADY !== 1'b0) begin
                fails++;
                $display("FAIL abort_pready cycle=%0d got %b want 0", k, PREADY);
            end
        end
        xfer(1'b0, BASE + 32'h10, '0);
        idle();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_error();
        test_back_to_back();
        test_abort();
        repeat (2) @(negedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB3 completer (slave) with a zero-initialised word-addressed register memory, programmable wait-state insertion and PSLVERR signalling. It is the responder end of the APB link that the operand-fetch / result-write initiator in TOP drives. It accepts read and write transfers, returns PRDATA/PREADY/PSLVERR with fully registered outputs, and lets benches run the initiator against real wait states and errors.

## Interface
Parameters:
- DATA_W, 32: PWDATA/PRDATA width.
- DEPTH, 16: number of words, power of 2, at least 2. IDX_W = log2(DEPTH).
- BASE_ADDR, 32'h1111_0000: window base. Must be aligned to DEPTH*4.
- WAIT_CYCLES, 2: wait states per transfer, range 0..15. Used only when APB_SLV_WAIT_EN is defined.

Ports (one clock; reset is asynchronous and active-low):
- PCLK, input, 1: clock. All logic is on the rising edge.
- PRESETn, input, 1: asynchronous active-low reset.
- PSEL, input, 1: slave select.
- PENABLE, input, 1: access phase.
- PWRITE, input, 1: 1 = write, 0 = read.
- PADDR, input, 32: byte address.
- PWDATA, input, DATA_W: write data.
- PRDATA, output, DATA_W: read data. Valid only while PREADY=1 and PSLVERR=0; 0 otherwise.
- PREADY, output, 1: transfer completes in this cycle.
- PSLVERR, output, 1: error response. Valid only while PREADY=1.

## Operation
- Decode:
  - idx = PADDR[IDX_W+1:2].
  - hit = (PADDR[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]) && (PADDR[1:0] == 2'b00).
- States: IDLE, WAIT, RESP.
- IDLE, when PSEL=1 and PENABLE=0 (setup phase):
  - Latch PADDR, PWRITE, PWDATA and hit.
  - If the wait count is 0, go to RESP. Otherwise load cnt = count and go to WAIT.
  - Any other input combination: stay in IDLE.
- WAIT:
  - PREADY=0.
  - cnt decrements each cycle. At the edge where cnt==1, go to RESP.
- RESP:
  - PREADY=1 for exactly one cycle.
  - If the latched hit=0: PSLVERR=1 and PRDATA=0.
  - Read with hit=1: PRDATA = mem[idx], sampled at the edge entering RESP.
  - Write with hit=1: mem[idx] <= latched PWDATA at the edge leaving RESP. This happens only if PSEL=1 and PENABLE=1 in that cycle.
  - Next state is always IDLE. A back-to-back setup in the following cycle is accepted from IDLE.
- Abort: PSEL=0 while in WAIT or RESP returns to IDLE at the next edge. No memory write occurs and outputs return to 0.
- Write with hit=0: memory is unchanged.
- Reset, at any time including mid-transfer:
  - State = IDLE, cnt = 0.
  - PRDATA = 0, PREADY = 0, PSLVERR = 0.
  - All memory words = 0.

## Timing
- All outputs are registered and change only on PCLK rising edges or asynchronously on reset.
- Zero wait: PREADY=1 in the first access cycle. A transfer takes 2 cycles (setup + access).
- N wait states: PREADY=0 for N access cycles, then 1 for one cycle. A transfer takes N+2 cycles.
- Read-after-write to the same word in back-to-back transfers returns the new data. The write commits before the next setup edge.
- PREADY is never high in two consecutive cycles.

## Configuration
- Macro: APB_SLV_WAIT_EN.
- Defined: the WAIT state and the 4-bit counter are present, and the wait count = WAIT_CYCLES.
- Undefined: the WAIT state and counter are removed and the wait count is fixed at 0. Every transfer is zero-wait and WAIT_CYCLES is ignored.

## Structure
- Shared package apb_pkg holds:
  - The state enum apb_slv_state_t (IDLE/WAIT/RESP).
  - The APB address width constant APB_AW = 32.
  - WAIT_CNT_W = 4.
- One sub-module, apb_wait_counter: a loadable down-counter with load, count and done_next outputs.
- The memory array and decode stay in apb_slave_mem.

## Test plan
- Reset: assert PRESETn=0 mid-WAIT. Required: all outputs 0 immediately. After release, a read of 32'h1111_0004 returns 0.
- Zero-wait, macro undefined: write 32'hDEAD_BEEF to 32'h1111_0008, then read it back. Required: PREADY=1 in the 2nd cycle of each transfer and PRDATA=32'hDEAD_BEEF.
- Wait states, macro defined, WAIT_CYCLES=3: read 32'h1111_003C. Required: PREADY=0 for 3 access cycles, then 1 for one cycle, with PSLVERR=0.
- Error response:
  - Write 5 to 32'h1211_1111. Required: PREADY=1 with PSLVERR=1 and PRDATA=0, and no word changes.
  - Write to unaligned 32'h1111_0002. Required: PSLVERR=1.
- Back-to-back: write 32'h0000_0A0B to 32'h1111_0000, then read it with no idle cycle between. Required: PRDATA=32'h0000_0A0B.
- Abort: drop PSEL during WAIT of a write of 7 to 32'h1111_0010. Required: state returns to IDLE and a later read returns 0.
